// File: rtl/axis_uart_tx.sv
// AXI-Stream to UART transmitter: one DATA_BITS word per handshake, sent LSB-first
// as start, data, optional parity and stop bits, paced by an external baud enable.
module axis_uart_tx #(
    parameter int PARITY_ENA  = 0,
    parameter int PARITY_TYPE = 0,
    parameter int STOP_BITS   = 1,
    parameter int DATA_BITS   = 8,
    parameter int DELAY       = 0
) (
    input  logic                 aclk,
    input  logic                 arst,
    input  logic [DATA_BITS-1:0] s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    input  logic                 uart_ena,
    output logic                 uart_hold,
    output logic                 txd
);

    localparam int B  = 1 + DATA_BITS + PARITY_ENA + STOP_BITS;
    localparam int CW = $clog2(B + 1);

    typedef enum logic [1:0] {IDLE, LOAD, TRANS} state_t;

    state_t               state_q, state_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [B-1:0]         frame_q, frame_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 tready_q, tready_d;
    logic                 hold_q, hold_d;
    logic                 txd_q, txd_d;
    logic                 par;

    always_comb begin
        par = 1'b0;
        case (PARITY_TYPE)
            0:       par = ^data_q;
            1:       par = ~^data_q;
            2:       par = 1'b1;
            default: par = 1'b0;
        endcase
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q  <= IDLE;
            data_q   <= '0;
            frame_q  <= '1;
            cnt_q    <= '0;
            tready_q <= 1'b0;
            hold_q   <= 1'b1;
            txd_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            frame_q  <= frame_d;
            cnt_q    <= cnt_d;
            tready_q <= tready_d;
            hold_q   <= hold_d;
            txd_q    <= txd_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        frame_d  = frame_q;
        cnt_d    = cnt_q;
        tready_d = tready_q;
        hold_d   = hold_q;
        txd_d    = txd_q;
        case (state_q)
            IDLE: begin
                tready_d = 1'b1;
                hold_d   = 1'b1;
                txd_d    = 1'b1;
                if (s_axis_tvalid && tready_q) begin
                    data_d   = s_axis_tdata;
                    tready_d = 1'b0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                // Upper bits default to 1 so the stop bits fall out of the fill.
                frame_d                = '1;
                frame_d[0]             = 1'b0;
                frame_d[DATA_BITS:1]   = data_q;
                if (PARITY_ENA != 0)
                    frame_d[DATA_BITS+1] = par;
                hold_d  = 1'b0;
                state_d = TRANS;
            end
            TRANS: begin
                if (uart_ena) begin
                    // Pulse B+1 closes the final stop-bit period; txd is already 1.
                    if (cnt_q == CW'(B)) begin
                        cnt_d    = '0;
                        hold_d   = 1'b1;
                        tready_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        txd_d   = frame_q[0];
                        frame_d = {1'b1, frame_q[B-1:1]};
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign s_axis_tready = tready_q;
    assign uart_hold     = hold_q;

    generate
        if (DELAY > 0) begin : g_dly
            logic [DELAY-1:0] txd_pipe;
            always_ff @(posedge aclk or posedge arst) begin
                if (arst) begin
                    txd_pipe <= '1;
                end else begin
                    txd_pipe[0] <= txd_q;
                    for (int i = 1; i < DELAY; i++)
                        txd_pipe[i] <= txd_pipe[i-1];
                end
            end
            assign txd = txd_pipe[DELAY-1];
        end else begin : g_nodly
            assign txd = txd_q;
        end
    endgenerate

endmodule

// File: tb/tb_axis_uart_tx.sv
// Directed bench for axis_uart_tx: four parameterisations share clock, reset and
// baud enable; each frame is compared bit-by-bit against hand-built expectations.
module tb_axis_uart_tx;

    logic       aclk;
    logic       arst;
    logic [8:0] tdata;
    logic [3:0] tvalid_v;
    logic [3:0] tready_v;
    logic [3:0] hold_v;
    logic [3:0] txd_v;
    logic       uart_ena;

    int checks = 0;
    int passed = 0;
    int fails  = 0;
    int per    = 16;
    int ecnt   = 0;

    // u0: 8N1, u1: 8E1, u2: 8O1, u3: 7 bits, mark parity, 2 stop, 2-stage delay
    axis_uart_tx u0 (
        .aclk(aclk), .arst(arst), .s_axis_tdata(tdata[7:0]), .s_axis_tvalid(tvalid_v[0]),
        .s_axis_tready(tready_v[0]), .uart_ena(uart_ena), .uart_hold(hold_v[0]), .txd(txd_v[0]));
    axis_uart_tx #(.PARITY_ENA(1), .PARITY_TYPE(0)) u1 (
        .aclk(aclk), .arst(arst), .s_axis_tdata(tdata[7:0]), .s_axis_tvalid(tvalid_v[1]),
        .s_axis_tready(tready_v[1]), .uart_ena(uart_ena), .uart_hold(hold_v[1]), .txd(txd_v[1]));
    axis_uart_tx #(.PARITY_ENA(1), .PARITY_TYPE(1)) u2 (
        .aclk(aclk), .arst(arst), .s_axis_tdata(tdata[7:0]), .s_axis_tvalid(tvalid_v[2]),
        .s_axis_tready(tready_v[2]), .uart_ena(uart_ena), .uart_hold(hold_v[2]), .txd(txd_v[2]));
    axis_uart_tx #(.DATA_BITS(7), .PARITY_ENA(1), .PARITY_TYPE(2), .STOP_BITS(2), .DELAY(2)) u3 (
        .aclk(aclk), .arst(arst), .s_axis_tdata(tdata[6:0]), .s_axis_tvalid(tvalid_v[3]),
        .s_axis_tready(tready_v[3]), .uart_ena(uart_ena), .uart_hold(hold_v[3]), .txd(txd_v[3]));

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    // Baud enable: one pulse every 'per' cycles; per=1 holds it high.
    initial begin
        uart_ena = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            ecnt = ecnt + 1;
            if (ecnt >= per) ecnt = 0;
            uart_ena = (ecnt == 0);
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, checks);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame bits in transmit order: start, data LSB first, parity, stop ones.
    function automatic logic [15:0] mk(input logic [8:0] d, input int db, input int pe,
                                       input logic p);
        logic [15:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < db; i++) f[1+i] = d[i];
        if (pe != 0) f[1+db] = p;
        return f;
    endfunction

    task automatic wait_ready(input int idx, input string tag);
        int t;
        t = 0;
        @(negedge aclk);
        while (tready_v[idx] !== 1'b1 && t < 2000) begin
            @(negedge aclk);
            t++;
        end
        chk({tag, "_ready_seen"}, (t < 2000), 1);
    endtask

    task automatic send(input int idx, input logic [8:0] d, input string tag);
        tdata = d;
        wait_ready(idx, tag);
        tvalid_v[idx] = 1'b1;
        @(posedge aclk);
        #1 tvalid_v[idx] = 1'b0;
    endtask

    task automatic expect_frame(input int idx, input logic [15:0] bits, input int n,
                                input string tag);
        int t;
        t = 0;
        @(negedge aclk);
        while (txd_v[idx] !== 1'b0 && t < 3000) begin
            @(negedge aclk);
            t++;
        end
        chk({tag, "_start_seen"}, (t < 3000), 1);
        if (t >= 3000) return;
        repeat (per / 2) @(negedge aclk);
        for (int j = 0; j < n; j++) begin
            chk($sformatf("%s_bit%0d", tag, j), txd_v[idx], bits[j]);
            if (j < n - 1) repeat (per) @(negedge aclk);
        end
    endtask

    initial begin
        logic [15:0] b;
        int          z;
        arst     = 1'b1;
        tvalid_v = '0;
        tdata    = '0;

        // Reset values
        repeat (3) @(negedge aclk);
        chk("rst_tready", tready_v, 4'h0);
        chk("rst_hold", hold_v, 4'hF);
        chk("rst_txd", txd_v, 4'hF);
        arst = 1'b0;
        @(posedge aclk);
        #1 chk("rst_release_tready", tready_v, 4'hF);

        // 8N1, 16-cycle bit period, 0x55
        per = 16;
        send(0, 9'h055, "t55");
        fork
            expect_frame(0, mk(9'h055, 8, 0, 1'b0), 10, "f55");
            begin
                int n, t;
                n = 0;
                t = 0;
                while (hold_v[0] !== 1'b0 && t < 100) begin
                    @(negedge aclk);
                    t++;
                end
                while (hold_v[0] === 1'b0 && n < 400) begin
                    @(negedge aclk);
                    n++;
                end
                chk("f55_hold_len_in_range", (n >= 161 && n <= 176), 1);
                chk("f55_tready_with_hold", tready_v[0], 1);
            end
        join

        // Even parity: 0xA5 -> 0, 0xA4 -> 1
        per = 4;
        send(1, 9'h0A5, "ta5");
        expect_frame(1, mk(9'h0A5, 8, 1, 1'b0), 11, "even_a5");
        send(1, 9'h0A4, "ta4");
        expect_frame(1, mk(9'h0A4, 8, 1, 1'b1), 11, "even_a4");

        // Odd parity: 0x03 -> 1, 0x01 -> 0
        send(2, 9'h003, "t03");
        expect_frame(2, mk(9'h003, 8, 1, 1'b1), 11, "odd_03");
        send(2, 9'h001, "t01");
        expect_frame(2, mk(9'h001, 8, 1, 1'b0), 11, "odd_01");

        // 7 data bits, mark parity, 2 stop bits: 0, seven 0s, 1, 1, 1
        send(3, 9'h000, "t7m");
        expect_frame(3, 16'hFF00, 11, "mark7");

        // Continuous uart_ena: exact latency and one bit per cycle
        per = 1;
        b = mk(9'h055, 8, 0, 1'b0);
        send(0, 9'h055, "tlat");
        @(negedge aclk);
        chk("lat_load_tready", tready_v[0], 0);
        chk("lat_load_hold", hold_v[0], 1);
        chk("lat_load_txd", txd_v[0], 1);
        @(negedge aclk);
        chk("lat_trans_hold", hold_v[0], 0);
        chk("lat_trans_txd", txd_v[0], 1);
        @(negedge aclk);
        chk("lat_start", txd_v[0], b[0]);
        for (int j = 1; j < 10; j++) begin
            @(negedge aclk);
            chk($sformatf("lat_bit%0d", j), txd_v[0], b[j]);
        end
        chk("lat_hold_last", hold_v[0], 0);
        @(negedge aclk);
        chk("lat_end_hold", hold_v[0], 1);
        chk("lat_end_tready", tready_v[0], 1);

        // Back-to-back with tvalid held; tdata swapped while busy
        per = 16;
        fork
            begin
                expect_frame(0, mk(9'h012, 8, 0, 1'b0), 10, "b2b_12");
                expect_frame(0, mk(9'h034, 8, 0, 1'b0), 10, "b2b_34");
            end
            begin
                tdata = 9'h012;
                wait_ready(0, "b2b_a");
                tvalid_v[0] = 1'b1;
                @(posedge aclk);
                #1 tdata = 9'h034;
                wait_ready(0, "b2b_b");
                @(posedge aclk);
                #1 tvalid_v[0] = 1'b0;
                @(negedge aclk);
                chk("b2b_tready_one_cycle", tready_v[0], 0);
            end
        join

        // Async reset in the middle of data bit 4
        send(0, 9'h000, "trst");
        z = 0;
        @(negedge aclk);
        while (txd_v[0] !== 1'b0 && z < 100) begin
            @(negedge aclk);
            z++;
        end
        repeat (5 * 16 + 8) @(negedge aclk);
        chk("rst_mid_pre_txd", txd_v[0], 0);
        #1 arst = 1'b1;
        #1;
        chk("rst_mid_txd", txd_v[0], 1);
        chk("rst_mid_hold", hold_v[0], 1);
        chk("rst_mid_tready", tready_v[0], 0);
        @(negedge aclk);
        arst = 1'b0;
        #1 chk("rst_mid_release_pre", tready_v[0], 0);
        @(posedge aclk);
        #1 chk("rst_mid_release_tready", tready_v[0], 1);
        z = 0;
        repeat (40) begin
            @(negedge aclk);
            if (txd_v[0] !== 1'b1) z++;
        end
        chk("rst_mid_no_resume", z, 0);
        send(0, 9'h080, "t80");
        expect_frame(0, mk(9'h080, 8, 0, 1'b0), 10, "post_rst_80");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
